// File: rtl/ysyx_25060170_pkg.sv
// Shared types and widths for the write-back unit.
package ysyx_25060170_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    typedef enum logic {
        WB_RUN,
        WB_HALT
    } wb_state_e;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   wdata;
        logic              wen;
        logic              ebreak;
    } wb_entry_t;

endpackage

// File: rtl/ysyx_25060170_wb_fifo.sv
// In-order FIFO of write-back entries with a per-slot occupancy view for hazard scans.
module ysyx_25060170_wb_fifo
    import ysyx_25060170_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  wb_entry_t             din_i,
    input  logic                  pop_i,
    output wb_entry_t             dout_o,
    output logic                  full_o,
    output logic                  empty_o,
    output wb_entry_t [DEPTH-1:0] entries_o,
    output logic      [DEPTH-1:0] valid_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    wb_entry_t [DEPTH-1:0] mem_q;
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic                  do_push, do_pop;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;
    assign dout_o    = mem_q[rd_ptr_q];
    assign entries_o = mem_q;

    // Slot i holds a live entry when its distance from the head is below count.
    always_comb begin
        valid_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            valid_o[i] = CW'(PW'(i) - rd_ptr_q) < count_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ysyx_25060170_wbu.sv
// Write-back unit: buffers EXU results, retires them in order into the GPR file,
// serves two bypassed read ports with pending-write flags, and halts on ebreak.
module ysyx_25060170_wbu
    import ysyx_25060170_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned XLEN  = ysyx_25060170_pkg::XLEN,
    parameter int unsigned NREG  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic              in_wen,
    input  logic              in_ebreak,
    input  logic              stall_i,
    input  logic [REG_AW-1:0] rs1_addr,
    output logic [XLEN-1:0]   rs1_data,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic [XLEN-1:0]   rs2_data,
    output logic              rs1_pending,
    output logic              rs2_pending,
    output logic              trap_o,
    output logic              halted_o,
    output logic [31:0]       retire_cnt_o
);

    wb_state_e             state_q;
    logic                  trap_q;
    logic [31:0]           retire_cnt_q;
    logic [XLEN-1:0]       gpr_q [NREG];

    wb_entry_t             in_entry, head;
    wb_entry_t [DEPTH-1:0] entries;
    logic      [DEPTH-1:0] valid;
    logic                  full, empty, push, pop, gpr_we;

    assign in_entry = '{rd: in_rd, wdata: in_wdata, wen: in_wen, ebreak: in_ebreak};
    assign in_ready = !full && (state_q == WB_RUN);
    assign push     = in_valid && in_ready;
    assign pop      = !empty && !stall_i && (state_q == WB_RUN);
    assign gpr_we   = pop && head.wen && !head.ebreak && (head.rd != '0);

    ysyx_25060170_wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_i   (push),
        .din_i    (in_entry),
        .pop_i    (pop),
        .dout_o   (head),
        .full_o   (full),
        .empty_o  (empty),
        .entries_o(entries),
        .valid_o  (valid)
    );

    // A retiring write is forwarded so readers never see the stale value in its cycle.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_addr != '0) rs1_data = (gpr_we && head.rd == rs1_addr) ? head.wdata : gpr_q[rs1_addr];
        if (rs2_addr != '0) rs2_data = (gpr_we && head.rd == rs2_addr) ? head.wdata : gpr_q[rs2_addr];
    end

    always_comb begin
        rs1_pending = 1'b0;
        rs2_pending = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid[i] && entries[i].wen && !entries[i].ebreak) begin
                if (rs1_addr != '0 && entries[i].rd == rs1_addr) rs1_pending = 1'b1;
                if (rs2_addr != '0 && entries[i].rd == rs2_addr) rs2_pending = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++) gpr_q[i] <= '0;
        end else if (gpr_we) begin
            gpr_q[head.rd] <= head.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= WB_RUN;
            trap_q       <= 1'b0;
            retire_cnt_q <= '0;
        end else begin
            trap_q <= 1'b0;
            if (pop) begin
                retire_cnt_q <= retire_cnt_q + 32'd1;
                if (head.ebreak) begin
                    state_q <= WB_HALT;
                    trap_q  <= 1'b1;
                end
            end
        end
    end

    assign trap_o       = trap_q;
    assign halted_o     = (state_q == WB_HALT);
    assign retire_cnt_o = retire_cnt_q;

endmodule

// File: tb/tb_ysyx_25060170_wbu.sv
// Directed self-checking bench for the write-back unit.
module tb_ysyx_25060170_wbu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_wdata = '0;
    logic        in_wen = 1'b0;
    logic        in_ebreak = 1'b0;
    logic        stall_i = 1'b0;
    logic [4:0]  rs1_addr = '0;
    logic [31:0] rs1_data;
    logic [4:0]  rs2_addr = '0;
    logic [31:0] rs2_data;
    logic        rs1_pending, rs2_pending;
    logic        trap_o, halted_o;
    logic [31:0] retire_cnt_o;

    int unsigned nvec = 0;
    int unsigned nmis = 0;

    always #5 clk = ~clk;

    ysyx_25060170_wbu #(
        .DEPTH(2),
        .XLEN (32),
        .NREG (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rd       (in_rd),
        .in_wdata    (in_wdata),
        .in_wen      (in_wen),
        .in_ebreak   (in_ebreak),
        .stall_i     (stall_i),
        .rs1_addr    (rs1_addr),
        .rs1_data    (rs1_data),
        .rs2_addr    (rs2_addr),
        .rs2_data    (rs2_data),
        .rs1_pending (rs1_pending),
        .rs2_pending (rs2_pending),
        .trap_o      (trap_o),
        .halted_o    (halted_o),
        .retire_cnt_o(retire_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] d,
                         input logic wen, input logic eb);
        in_valid  = v;
        in_rd     = rd;
        in_wdata  = d;
        in_wen    = wen;
        in_ebreak = eb;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        rs1_addr = 5'd5;
        #1;
        chk("rst_ready",  {31'd0, in_ready}, 32'd1);
        chk("rst_halted", {31'd0, halted_o}, 32'd0);
        chk("rst_trap",   {31'd0, trap_o},   32'd0);
        chk("rst_cnt",    retire_cnt_o,      32'd0);
        chk("rst_rs1",    rs1_data,          32'd0);

        // 2: single write, bypass then array read
        drive(1, 5'd5, 32'h1234_5678, 1, 0);
        tick();
        drive(0, 5'd0, 32'd0, 0, 0);
        #1;
        chk("t2_pend",   {31'd0, rs1_pending}, 32'd1);
        chk("t2_bypass", rs1_data,             32'h1234_5678);
        tick();
        chk("t2_pend0",  {31'd0, rs1_pending}, 32'd0);
        chk("t2_array",  rs1_data,             32'h1234_5678);
        chk("t2_cnt",    retire_cnt_o,         32'd1);

        // 3: write to x0 is dropped but still counted
        drive(1, 5'd0, 32'hDEAD_BEEF, 1, 0);
        tick();
        drive(0, 5'd0, 32'd0, 0, 0);
        rs1_addr = 5'd0;
        #1;
        chk("t3_pend",  {31'd0, rs1_pending}, 32'd0);
        chk("t3_x0",    rs1_data,             32'd0);
        tick();
        chk("t3_x0b",   rs1_data,             32'd0);
        chk("t3_cnt",   retire_cnt_o,         32'd2);

        // 4: stall fills the FIFO, then drains in order
        stall_i = 1'b1;
        drive(1, 5'd1, 32'd1, 1, 0);
        #1 chk("t4_rdy1", {31'd0, in_ready}, 32'd1);
        tick();
        drive(1, 5'd2, 32'd2, 1, 0);
        #1 chk("t4_rdy2", {31'd0, in_ready}, 32'd1);
        tick();
        drive(1, 5'd6, 32'h66, 1, 0);
        #1 chk("t4_full", {31'd0, in_ready}, 32'd0);
        tick();
        chk("t4_held",  {31'd0, in_ready}, 32'd0);
        chk("t4_cnt0",  retire_cnt_o,      32'd2);
        stall_i  = 1'b0;
        rs1_addr = 5'd1;
        rs2_addr = 5'd2;
        #1;
        chk("t4_rdy_pop", {31'd0, in_ready}, 32'd0);
        chk("t4_x1_byp",  rs1_data,          32'd1);
        chk("t4_x2_old",  rs2_data,          32'd0);
        tick();
        chk("t4_cnt1",  retire_cnt_o,      32'd3);
        chk("t4_rdy3",  {31'd0, in_ready}, 32'd1);
        chk("t4_x1",    rs1_data,          32'd1);
        chk("t4_x2byp", rs2_data,          32'd2);
        tick();
        drive(0, 5'd0, 32'd0, 0, 0);
        rs1_addr = 5'd6;
        #1;
        chk("t4_cnt2",  retire_cnt_o,         32'd4);
        chk("t4_x6pend", {31'd0, rs1_pending}, 32'd1);
        tick();
        chk("t4_x6",    rs1_data,     32'h66);
        chk("t4_cnt3",  retire_cnt_o, 32'd5);

        // 5: ebreak traps, halts, blocks younger entries; reset clears all
        drive(1, 5'd0, 32'd0, 0, 1);
        tick();
        drive(1, 5'd3, 32'd7, 1, 0);
        #1 chk("t5_notrap", {31'd0, trap_o}, 32'd0);
        tick();
        drive(0, 5'd0, 32'd0, 0, 0);
        rs1_addr = 5'd3;
        #1;
        chk("t5_trap",   {31'd0, trap_o},   32'd1);
        chk("t5_halt",   {31'd0, halted_o}, 32'd1);
        chk("t5_rdy",    {31'd0, in_ready}, 32'd0);
        chk("t5_cnt",    retire_cnt_o,      32'd6);
        tick();
        chk("t5_trap1",  {31'd0, trap_o},   32'd0);
        tick();
        tick();
        chk("t5_halt2",  {31'd0, halted_o},    32'd1);
        chk("t5_x3",     rs1_data,             32'd0);
        chk("t5_x3pend", {31'd0, rs1_pending}, 32'd1);
        chk("t5_cnt2",   retire_cnt_o,         32'd6);
        rst = 1'b0;
        #1;
        chk("t5_r_halt", {31'd0, halted_o},    32'd0);
        chk("t5_r_cnt",  retire_cnt_o,         32'd0);
        chk("t5_r_pend", {31'd0, rs1_pending}, 32'd0);
        rs1_addr = 5'd5;
        #1 chk("t5_r_x5", rs1_data, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("t5_r_rdy", {31'd0, in_ready}, 32'd1);

        // 6: back-to-back writes to the same register
        rs1_addr = 5'd4;
        drive(1, 5'd4, 32'd1, 1, 0);
        tick();
        drive(1, 5'd4, 32'd2, 1, 0);
        #1 chk("t6_pend1", {31'd0, rs1_pending}, 32'd1);
        tick();
        drive(0, 5'd0, 32'd0, 0, 0);
        #1;
        chk("t6_pend2", {31'd0, rs1_pending}, 32'd1);
        chk("t6_byp",   rs1_data,             32'd2);
        tick();
        chk("t6_pend3", {31'd0, rs1_pending}, 32'd0);
        chk("t6_x4",    rs1_data,             32'd2);
        chk("t6_cnt",   retire_cnt_o,         32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
